// File: rtl/prbs_lane_scan_ctrl.sv
// Time-shares one parallel PRBS-7 checker across NLANES receive lanes: select, settle,
// measure an error window, record per-lane pass/fail and error count.
module prbs_lane_scan_ctrl #(
  parameter int unsigned NLANES     = 4,
  parameter int unsigned NBITS      = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned WINDOW_CYC = 1024,
  parameter int unsigned ERRCNT_W   = 16,
  localparam int unsigned LW        = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    start_i,
  input  logic [NLANES-1:0]       lane_mask_i,
  input  logic [NLANES*NBITS-1:0] data_lanes_i,
  output logic [NBITS-1:0]        chk_data_o,
  output logic                    chk_en_o,
  input  logic                    chk_error_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LW-1:0]           cur_lane_o,
  output logic [ERRCNT_W-1:0]     err_cnt_o,
  output logic                    err_cnt_vld_o,
  output logic [NLANES-1:0]       lane_pass_o
);

  localparam int unsigned TMAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW_CYC - 1);

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, MEASURE, RECORD, DONE} state_t;

  state_t              state, state_nxt;
  logic [NLANES-1:0]   mask;
  logic [LW-1:0]       cur_lane, first_lane, next_lane;
  logic                has_next;
  logic [TW-1:0]       tmr;
  logic                tmr_last;
  logic [ERRCNT_W-1:0] cnt, cnt_nxt;

  assign cur_lane_o = cur_lane;
  assign tmr_last   = (state == SETTLE) ? (tmr == SETTLE_LAST) : (tmr == WINDOW_LAST);
  assign cnt_nxt    = (chk_error_i && (cnt != '1)) ? cnt + ERRCNT_W'(1) : cnt;

  // Descending scan so the lowest qualifying lane index wins.
  always_comb begin
    first_lane = '0;
    next_lane  = '0;
    has_next   = 1'b0;
    for (int unsigned i = NLANES; i > 0; i--) begin
      if (lane_mask_i[i-1]) first_lane = LW'(i - 1);
      if (mask[i-1] && (LW'(i - 1) > cur_lane)) begin
        next_lane = LW'(i - 1);
        has_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (|lane_mask_i) ? SELECT : DONE;
      SELECT:  state_nxt = SETTLE;
      SETTLE:  if (tmr_last) state_nxt = MEASURE;
      MEASURE: if (tmr_last) state_nxt = RECORD;
      RECORD:  state_nxt = has_next ? SELECT : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    chk_en_o      = (state == SETTLE) || (state == MEASURE);
    busy_o        = state inside {SELECT, SETTLE, MEASURE, RECORD};
    done_o        = (state == DONE);
    err_cnt_vld_o = (state == RECORD);
  end

  // Result registers load on the MEASURE->RECORD edge (including the final window
  // sample) so they are already valid while err_cnt_vld_o is high in RECORD.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      chk_data_o  <= '0;
      mask        <= '0;
      cur_lane    <= '0;
      tmr         <= '0;
      cnt         <= '0;
      err_cnt_o   <= '0;
      lane_pass_o <= '0;
    end else begin
      chk_data_o <= data_lanes_i[cur_lane*NBITS +: NBITS];
      if (state_nxt != state) tmr <= '0;
      else if (chk_en_o)      tmr <= tmr + TW'(1);
      if ((state_nxt == SELECT) && (state != SELECT)) cnt <= '0;
      case (state)
        IDLE: begin
          if (start_i) begin
            lane_pass_o <= '0;
            if (|lane_mask_i) begin
              mask     <= lane_mask_i;
              cur_lane <= first_lane;
            end
          end
        end
        MEASURE: begin
          cnt <= cnt_nxt;
          if (tmr_last) begin
            err_cnt_o             <= cnt_nxt;
            lane_pass_o[cur_lane] <= (cnt_nxt == '0);
          end
        end
        RECORD: if (has_next) cur_lane <= next_lane;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_lane_scan_ctrl.sv
// Bench for prbs_lane_scan_ctrl: PRBS-7 lane sources, a shared checker model, and a
// timeline scoreboard derived from per-lane phase arithmetic.
module tb_prbs_lane_scan_ctrl;

  localparam int S  = 4;
  localparam int W  = 64;
  localparam int P  = 2 + S + W;

  logic        clk = 1'b0;
  logic        resetn_i, start_i, chk_error_i;
  logic [3:0]  lane_mask_i;
  logic [31:0] data_lanes_i;

  logic [7:0]  chk_data_o, chk_data_b;
  logic        chk_en_o, chk_en_b, busy_o, busy_b, done_o, done_b;
  logic [1:0]  cur_lane_o, cur_lane_b;
  logic [15:0] err_cnt_o;
  logic [3:0]  err_cnt_b;
  logic        err_cnt_vld_o, err_cnt_vld_b;
  logic [3:0]  lane_pass_o, lane_pass_b;

  always #5 clk = ~clk;

  prbs_lane_scan_ctrl #(.NLANES(4), .NBITS(8), .SETTLE_CYC(S), .WINDOW_CYC(W), .ERRCNT_W(16)) dut (
    .clk_i(clk), .resetn_i(resetn_i), .start_i(start_i), .lane_mask_i(lane_mask_i),
    .data_lanes_i(data_lanes_i), .chk_data_o(chk_data_o), .chk_en_o(chk_en_o),
    .chk_error_i(chk_error_i), .busy_o(busy_o), .done_o(done_o), .cur_lane_o(cur_lane_o),
    .err_cnt_o(err_cnt_o), .err_cnt_vld_o(err_cnt_vld_o), .lane_pass_o(lane_pass_o));

  // Narrow-counter instance sharing all inputs; only its saturation point differs.
  prbs_lane_scan_ctrl #(.NLANES(4), .NBITS(8), .SETTLE_CYC(S), .WINDOW_CYC(W), .ERRCNT_W(4)) dut_sat (
    .clk_i(clk), .resetn_i(resetn_i), .start_i(start_i), .lane_mask_i(lane_mask_i),
    .data_lanes_i(data_lanes_i), .chk_data_o(chk_data_b), .chk_en_o(chk_en_b),
    .chk_error_i(chk_error_i), .busy_o(busy_b), .done_o(done_b), .cur_lane_o(cur_lane_b),
    .err_cnt_o(err_cnt_b), .err_cnt_vld_o(err_cnt_vld_b), .lane_pass_o(lane_pass_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Lane sources and checker model
  logic [6:0] gen [4];
  int         mode [4];
  bit         flip [4];
  logic [6:0] hist;
  logic       en_s;
  logic [7:0] d_s;

  task automatic tick();
    logic [14:0] seq;
    logic        e;
    logic [6:0]  g;
    logic [7:0]  w;
    @(negedge clk);
    en_s = chk_en_o;
    d_s  = chk_data_o;
    @(posedge clk);
    #1;
    e = 1'b0;
    if (en_s) begin
      seq = {d_s, hist};
      for (int j = 7; j < 15; j++) if (seq[j] != (seq[j-7] ^ seq[j-6])) e = 1'b1;
      if (d_s == 8'h00) e = 1'b1;
      hist = seq[14:8];
    end
    chk_error_i = e;
    for (int l = 0; l < 4; l++) begin
      g = gen[l];
      for (int b = 0; b < 8; b++) begin
        w[b] = g[0] ^ g[1];
        g    = {w[b], g[6:1]};
      end
      gen[l] = g;
      if (mode[l] == 1) w = 8'h00;
      if (flip[l]) begin
        w[3]    = ~w[3];
        flip[l] = 1'b0;
      end
      data_lanes_i[l*8 +: 8] = w;
    end
  endtask

  // Scoreboard
  int          cyc = 0, t0 = 0, cnt = 0;
  bit          scan = 1'b0, prev_rst = 1'b1, idle;
  int          lanes [$];
  int          exp_cur = 0, prev_cur = 0, exp_err = 0, exp_err_b = 0;
  logic [3:0]  exp_pass = '0;
  logic [31:0] prev_data = '0;
  int          rec_lane [$];
  int          rec_cnt [$];
  int          done_rel = -1, done_cnt = 0;
  int          rel, idx, ph;
  bit          e_busy, e_done, e_en, e_vld;
  logic [7:0]  e_data;

  always @(negedge clk) begin
    e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0; e_vld = 1'b0;
    idle = 1'b0;
    if (!resetn_i) begin
      scan = 1'b0; exp_cur = 0; exp_pass = '0; exp_err = 0; exp_err_b = 0;
      e_data = 8'h00;
    end else begin
      e_data = prev_rst ? 8'h00 : prev_data[prev_cur*8 +: 8];
      idle   = !scan;
      if (scan) begin
        rel = cyc - t0;
        if (rel <= lanes.size() * P) begin
          idx     = (rel - 1) / P;
          ph      = (rel - 1) % P;
          exp_cur = lanes[idx];
          e_busy  = 1'b1;
          if (ph == 0) cnt = 0;
          e_en = (ph >= 1) && (ph <= S + W);
          if ((ph > S) && (ph <= S + W) && chk_error_i) cnt++;
          if (ph == S + W + 1) begin
            e_vld     = 1'b1;
            exp_err   = (cnt > 65535) ? 65535 : cnt;
            exp_err_b = (cnt > 15) ? 15 : cnt;
            exp_pass[exp_cur] = (cnt == 0);
            rec_lane.push_back(exp_cur);
            rec_cnt.push_back(cnt);
          end
        end else begin
          e_done   = 1'b1;
          scan     = 1'b0;
          done_rel = rel;
          done_cnt++;
        end
      end
    end
    check("busy", busy_o, e_busy);
    check("done", done_o, e_done);
    check("chk_en", chk_en_o, e_en);
    check("vld", err_cnt_vld_o, e_vld);
    check("cur_lane", cur_lane_o, exp_cur);
    check("chk_data", chk_data_o, e_data);
    check("err_cnt", err_cnt_o, exp_err);
    check("pass", lane_pass_o, exp_pass);
    check("sat_busy", busy_b, e_busy);
    check("sat_done", done_b, e_done);
    check("sat_vld", err_cnt_vld_b, e_vld);
    check("sat_err_cnt", err_cnt_b, exp_err_b);
    check("sat_pass", lane_pass_b, exp_pass);
    if (resetn_i && idle && start_i) begin
      scan = 1'b1;
      t0   = cyc;
      lanes.delete();
      for (int l = 0; l < 4; l++) if (lane_mask_i[l]) lanes.push_back(l);
      exp_pass = '0;
    end
    prev_data = data_lanes_i;
    prev_cur  = exp_cur;
    prev_rst  = !resetn_i;
    cyc++;
  end

  task automatic run_scan(input logic [3:0] m, input int flip_at, input int restart_at);
    int base;
    base = done_cnt;
    rec_lane.delete();
    rec_cnt.delete();
    lane_mask_i = m;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
    lane_mask_i = ~m;
    for (int k = 1; k <= 2000 && done_cnt == base; k++) begin
      if (k == flip_at) flip[3] = 1'b1;
      start_i = (k == restart_at);
      tick();
    end
    start_i = 1'b0;
    check("scan_done_count", done_cnt - base, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c;
    resetn_i = 1'b0; start_i = 1'b0; lane_mask_i = '0; data_lanes_i = '0; chk_error_i = 1'b0;
    hist = '0;
    for (int l = 0; l < 4; l++) begin
      gen[l]  = 7'(l * 19 + 5);
      mode[l] = 0;
      flip[l] = 1'b0;
    end
    repeat (3) tick();
    check("rst_busy", busy_o, 0);
    check("rst_pass", lane_pass_o, 0);
    resetn_i = 1'b1;
    repeat (3) tick();

    // All lanes clean, with a stray start mid-scan
    run_scan(4'b1111, 0, 50);
    check("t1_done_latency", done_rel, 4 * 70 + 1);
    check("t1_nrec", rec_lane.size(), 4);
    for (int i = 0; i < rec_lane.size() && i < 4; i++) begin
      check("t1_lane_order", rec_lane[i], i);
      check("t1_cnt", rec_cnt[i], 0);
    end
    check("t1_pass", lane_pass_o, 4'b1111);

    // Lane 2 stuck at zero
    mode[2] = 1;
    run_scan(4'b1111, 0, 0);
    mode[2] = 0;
    check("t2_nrec", rec_lane.size(), 4);
    if (rec_cnt.size() == 4) begin
      check("t2_cnt0", rec_cnt[0], 0);
      check("t2_cnt2", rec_cnt[2], 64);
      check("t2_cnt3", rec_cnt[3], 0);
    end
    check("t2_pass", lane_pass_o, 4'b1011);
    check("t2_sat_pass", lane_pass_b, 4'b1011);

    // Saturation on the 4-bit instance, lane 0 stuck at zero
    mode[0] = 1;
    run_scan(4'b0001, 0, 0);
    mode[0] = 0;
    check("t3_err_cnt", err_cnt_o, 64);
    check("t3_sat_err_cnt", err_cnt_b, 15);
    check("t3_sat_pass0", lane_pass_b[0], 0);

    // Single bit flip on lane 3 mid-window
    run_scan(4'b1010, 110, 0);
    check("t4_nrec", rec_lane.size(), 2);
    if (rec_lane.size() == 2) begin
      check("t4_lane_a", rec_lane[0], 1);
      check("t4_lane_b", rec_lane[1], 3);
      check("t4_cnt1", rec_cnt[0], 0);
      c = rec_cnt[1];
      check("t4_cnt3_range", (c >= 1 && c <= 3), 1);
    end
    check("t4_dut_cnt_range", (err_cnt_o >= 1 && err_cnt_o <= 3), 1);
    check("t4_pass", lane_pass_o, 4'b0010);

    // Empty mask
    run_scan(4'b0000, 0, 0);
    check("t5_done_latency", done_rel, 1);
    check("t5_nrec", rec_lane.size(), 0);
    check("t5_pass", lane_pass_o, 4'b0000);

    // Reset during lane 1 measurement, then rescan
    lane_mask_i = 4'b1111;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (79) tick();
    check("t6_pre_busy", busy_o, 1);
    check("t6_pre_en", chk_en_o, 1);
    check("t6_pre_cur", cur_lane_o, 1);
    check("t6_pre_pass", lane_pass_o, 4'b0001);
    base = done_cnt;
    resetn_i = 1'b0;
    #1;
    check("t6_busy", busy_o, 0);
    check("t6_en", chk_en_o, 0);
    check("t6_cur", cur_lane_o, 0);
    check("t6_pass", lane_pass_o, 0);
    check("t6_data", chk_data_o, 0);
    tick();
    tick();
    resetn_i = 1'b1;
    tick();
    check("t6_no_done", done_cnt - base, 0);
    run_scan(4'b1111, 0, 0);
    check("t6_nrec", rec_lane.size(), 4);
    if (rec_lane.size() == 4) check("t6_first_lane", rec_lane[0], 0);
    check("t6_pass_after", lane_pass_o, 4'b1111);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
